// File: rtl/spi_device_core.sv
// SPI device engine: oversampled SPI slave, single-entry TX/RX buffers.
// Define SPI_DEVICE_LOOPBACK_EN to add the CTRL[5] LOOP self-test path.
module spi_device_core #(
    parameter int unsigned SyncStages = 2,
    parameter int unsigned MaxLen     = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    input  logic        we_i,
    input  logic        re_i,
    output logic [31:0] rdata_o,
    output logic        error_o,
    output logic        intr_o,
    input  logic        sclk_i,
    input  logic        ss_ni,
    input  logic        sd_i,
    output logic        sd_o,
    output logic        sd_oe_o
);

    typedef enum logic {IDLE, ACTIVE} state_e;

`ifdef SPI_DEVICE_LOOPBACK_EN
    localparam logic [31:0] CtrlMask = 32'h0000_1F3F;
`else
    localparam logic [31:0] CtrlMask = 32'h0000_1F1F;
`endif

    function automatic logic [31:0] merge_be(input logic [31:0] old,
                                             input logic [31:0] nw,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = be[i] ? nw[i*8 +: 8] : old[i*8 +: 8];
        end
        return r;
    endfunction

    logic [SyncStages-1:0] sclk_sync, ss_sync, sd_sync;
    logic                  sclk_s, ss_s, sd_s, sclk_q, ss_q;
    state_e                state_q, state_d;
    logic                  active, stay, enter, load;
    logic [31:0]           ctrl_q, tx_buf, rx_buf;
    logic                  rxv_q, txe_q, ovr_q, udr_q;
    logic                  cfg_cpol, cfg_cpha, cfg_lsbf;
    logic [4:0]            cfg_len, bit_cnt, idx;
    logic [MaxLen-1:0]     tx_shift, rx_shift, rx_word;
    logic                  sd_q, out_bit, din, loop_act;
    logic                  sclk_edge, lead, trail, sample_ev, shift_ev, done;
    logic                  ss_fall, ss_rise, en;
    logic                  sel_ctrl, sel_stat, sel_tx, sel_rx, mapped;
    logic                  wr_ctrl, wr_stat, wr_tx, rd_rx;
    logic [31:0]           tx_new;
    logic                  unused_addr;

    assign unused_addr = ^addr_i[1:0];

    // ss_n synchronizer resets to deselected so reset never looks like a select
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            sd_sync   <= '0;
            sclk_q    <= 1'b0;
            ss_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SyncStages-2:0], sclk_i};
            ss_sync   <= {ss_sync[SyncStages-2:0], ss_ni};
            sd_sync   <= {sd_sync[SyncStages-2:0], sd_i};
            sclk_q    <= sclk_s;
            ss_q      <= ss_s;
        end
    end

    assign sclk_s = sclk_sync[SyncStages-1];
    assign ss_s   = ss_sync[SyncStages-1];
    assign sd_s   = sd_sync[SyncStages-1];

    assign ss_fall   = ss_q & ~ss_s;
    assign ss_rise   = ~ss_q & ss_s;
    assign sclk_edge = sclk_s ^ sclk_q;
    assign lead      = sclk_edge & (sclk_s != cfg_cpol);
    assign trail     = sclk_edge & (sclk_s == cfg_cpol);
    assign en        = ctrl_q[0];

    // bit 0 of each character is already on the line, so the first shift is skipped
    assign sample_ev = active & (cfg_cpha ? trail : lead);
    assign shift_ev  = active & (cfg_cpha ? lead : trail) & (bit_cnt != 5'd0);
    assign done      = sample_ev & (bit_cnt == cfg_len);

    assign out_bit = cfg_lsbf ? tx_shift[0] : tx_shift[cfg_len];
    assign idx     = cfg_lsbf ? bit_cnt : cfg_len - bit_cnt;
    assign rx_word = rx_shift | ({{(MaxLen-1){1'b0}}, din} << idx);

`ifdef SPI_DEVICE_LOOPBACK_EN
    logic cfg_loop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_loop <= 1'b0;
        end else if (!active) begin
            cfg_loop <= ctrl_q[5];
        end
    end

    assign din      = cfg_loop ? out_bit : sd_s;
    assign loop_act = cfg_loop;
`else
    assign din      = sd_s;
    assign loop_act = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall && en) state_d = ACTIVE;
            ACTIVE:  if (ss_rise || !en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        active  = (state_q == ACTIVE);
        sd_oe_o = active & ~loop_act;
        intr_o  = ctrl_q[4] & (rxv_q | ovr_q | udr_q);
        sd_o    = sd_q;
    end

    assign stay  = (state_d == ACTIVE);
    assign enter = ~active & stay;
    assign load  = enter | (done & stay);

    assign sel_ctrl = (addr_i[7:2] == 6'd0);
    assign sel_stat = (addr_i[7:2] == 6'd1);
    assign sel_tx   = (addr_i[7:2] == 6'd2);
    assign sel_rx   = (addr_i[7:2] == 6'd3);
    assign mapped   = sel_ctrl | sel_stat | sel_tx | sel_rx;
    assign wr_ctrl  = we_i & sel_ctrl;
    assign wr_stat  = we_i & sel_stat;
    assign wr_tx    = we_i & sel_tx;
    assign rd_rx    = re_i & sel_rx;
    assign tx_new   = merge_be(tx_buf, wdata_i, be_i);
    assign error_o  = (we_i | re_i) & ~mapped;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q   <= '0;
            cfg_cpol <= 1'b0;
            cfg_cpha <= 1'b0;
            cfg_lsbf <= 1'b0;
            cfg_len  <= '0;
        end else begin
            if (wr_ctrl) ctrl_q <= merge_be(ctrl_q, wdata_i, be_i) & CtrlMask;
            if (!active) begin
                cfg_cpol <= ctrl_q[1];
                cfg_cpha <= ctrl_q[2];
                cfg_lsbf <= ctrl_q[3];
                cfg_len  <= ctrl_q[12:8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_buf   <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_buf   <= '0;
            bit_cnt  <= '0;
            rxv_q    <= 1'b0;
            txe_q    <= 1'b1;
            ovr_q    <= 1'b0;
            udr_q    <= 1'b0;
            sd_q     <= 1'b0;
        end else begin
            sd_q <= out_bit;
            if (wr_tx) tx_buf <= tx_new;
            if (wr_stat && be_i[0]) begin
                if (wdata_i[2]) ovr_q <= 1'b0;
                if (wdata_i[3]) udr_q <= 1'b0;
            end
            // a TXDATA write landing with a load goes straight to the shifter
            if (load) begin
                if (wr_tx) begin
                    tx_shift <= tx_new;
                end else if (txe_q) begin
                    tx_shift <= '0;
                    udr_q    <= 1'b1;
                end else begin
                    tx_shift <= tx_buf;
                end
                txe_q <= 1'b1;
            end else begin
                if (shift_ev) begin
                    tx_shift <= cfg_lsbf ? {1'b0, tx_shift[MaxLen-1:1]}
                                         : {tx_shift[MaxLen-2:0], 1'b0};
                end
                if (wr_tx) txe_q <= 1'b0;
            end
            if (!stay || load) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (sample_ev) begin
                bit_cnt  <= bit_cnt + 5'd1;
                rx_shift <= rx_word;
            end
            if (done) begin
                if (rxv_q && !rd_rx) begin
                    ovr_q <= 1'b1;
                end else begin
                    rx_buf <= rx_word;
                    rxv_q  <= 1'b1;
                end
            end else if (rd_rx) begin
                rxv_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        unique case (1'b1)
            sel_ctrl: rdata_o = ctrl_q;
            sel_stat: rdata_o = {27'd0, active, udr_q, ovr_q, txe_q, rxv_q};
            sel_rx:   rdata_o = rx_buf;
            default:  rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_spi_device_core.sv
// Directed bench for spi_device_core acting as the SPI master.
module tb_spi_device_core;

    localparam int HALF = 6;

`ifdef SPI_DEVICE_LOOPBACK_EN
    localparam logic [31:0] CTRL_ALL = 32'h0000_1F3F;
`else
    localparam logic [31:0] CTRL_ALL = 32'h0000_1F1F;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we, re;
    logic [31:0] rdata;
    logic        err, intr;
    logic        sclk, ss_n, mosi_pin, miso_pin, miso_oe;

    int checks = 0;
    int errors = 0;

    spi_device_core dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .addr_i  (addr),
        .wdata_i (wdata),
        .be_i    (be),
        .we_i    (we),
        .re_i    (re),
        .rdata_o (rdata),
        .error_o (err),
        .intr_o  (intr),
        .sclk_i  (sclk),
        .ss_ni   (ss_n),
        .sd_i    (mosi_pin),
        .sd_o    (miso_pin),
        .sd_oe_o (miso_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] b);
        @(negedge clk);
        addr = a; wdata = d; be = b; we = 1'b1;
        @(negedge clk);
        we = 1'b0; be = 4'h0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d,
                            output logic e);
        @(negedge clk);
        addr = a; re = 1'b1;
        #1;
        d = rdata; e = err;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic spi_xfer(input logic [31:0] tx, input int len,
                            input logic cpol, input logic cpha,
                            input logic lsbf, input int stop_after,
                            input logic exp_oe, output logic [31:0] rx);
        int   b;
        logic oe_bad;
        rx = '0;
        oe_bad = 1'b0;
        sclk = cpol;
        wait_clk(4);
        ss_n = 1'b0;
        wait_clk(8);
        check("oe_entry", {31'd0, miso_oe}, {31'd0, exp_oe});
        for (int i = 0; i < len; i++) begin
            if (i == stop_after) break;
            b = lsbf ? i : len - 1 - i;
            if (!cpha) begin
                mosi_pin = tx[b];
                wait_clk(HALF);
                sclk = ~cpol;
                rx[b] = miso_pin;
                if (miso_oe !== exp_oe) oe_bad = 1'b1;
                wait_clk(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi_pin = tx[b];
                wait_clk(HALF);
                rx[b] = miso_pin;
                if (miso_oe !== exp_oe) oe_bad = 1'b1;
                sclk = cpol;
                wait_clk(HALF);
            end
        end
        wait_clk(HALF);
        ss_n = 1'b1;
        wait_clk(10);
        check("oe_hold_bad", {31'd0, oe_bad}, 32'd0);
    endtask

    logic [31:0] d, miso;
    logic        e;

    initial begin
        rst_n = 1'b0;
        addr = '0; wdata = '0; be = '0; we = 1'b0; re = 1'b0;
        sclk = 1'b0; ss_n = 1'b1; mosi_pin = 1'b0;
        wait_clk(3);
        #1;
        check("rst_sd_o", {31'd0, miso_pin}, 32'd0);
        check("rst_sd_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_intr", {31'd0, intr}, 32'd0);
        check("rst_error", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk(2);
        bus_read(8'h04, d, e);
        check("rst_status", d, 32'h2);
        bus_read(8'h00, d, e);
        check("rst_ctrl", d, 32'h0);

        // mode 0, 32-bit, IE
        bus_write(8'h00, 32'h0000_1F11, 4'hF);
        bus_write(8'h08, 32'hA5A5_0F0F, 4'hF);
        bus_read(8'h04, d, e);
        check("m0_txe_clr", d, 32'h0);
        spi_xfer(32'h1234_5678, 32, 1'b0, 1'b0, 1'b0, 99, 1'b1, miso);
        check("m0_miso", miso, 32'hA5A5_0F0F);
        bus_read(8'h04, d, e);
        check("m0_status", d, 32'h0B);
        check("m0_intr_set", {31'd0, intr}, 32'd1);
        bus_read(8'h0C, d, e);
        check("m0_rxdata", d, 32'h1234_5678);
        bus_write(8'h04, 32'h8, 4'h1);
        check("m0_intr_clr", {31'd0, intr}, 32'd0);
        bus_read(8'h04, d, e);
        check("m0_status2", d, 32'h2);

        // mode 3, LSB first, 8-bit; first character with empty TX
        bus_write(8'h00, 32'h0000_070F, 4'hF);
        spi_xfer(32'h81, 8, 1'b1, 1'b1, 1'b1, 99, 1'b1, miso);
        check("m3_udr_miso", miso, 32'h0);
        bus_read(8'h04, d, e);
        check("m3_status1", d, 32'h0B);
        check("m3_intr_ie0", {31'd0, intr}, 32'd0);
        bus_write(8'h08, 32'h0000_00C3, 4'hF);
        spi_xfer(32'h3C, 8, 1'b1, 1'b1, 1'b1, 99, 1'b1, miso);
        check("m3_miso", miso, 32'hC3);
        bus_read(8'h04, d, e);
        check("m3_status_ovr", d, 32'h0F);
        bus_read(8'h0C, d, e);
        check("m3_rxdata_old", d, 32'h81);
        bus_write(8'h04, 32'h0000_000C, 4'h1);
        bus_read(8'h04, d, e);
        check("m3_w1c", d, 32'h2);

        // aborted character, then a clean one
        bus_write(8'h00, 32'h0000_0701, 4'hF);
        bus_write(8'h08, 32'h0000_00FF, 4'hF);
        spi_xfer(32'hFF, 8, 1'b0, 1'b0, 1'b0, 5, 1'b1, miso);
        bus_read(8'h04, d, e);
        check("abort_status", d, 32'h2);
        bus_write(8'h08, 32'h0000_0096, 4'hF);
        spi_xfer(32'h5A, 8, 1'b0, 1'b0, 1'b0, 99, 1'b1, miso);
        check("abort_next_miso", miso, 32'h96);
        bus_read(8'h04, d, e);
        check("abort_next_status", d, 32'h0B);
        bus_read(8'h0C, d, e);
        check("abort_next_rx", d, 32'h5A);

        // register map edges
        bus_read(8'h10, d, e);
        check("unmapped_err", {31'd0, e}, 32'd1);
        check("unmapped_data", d, 32'h0);
        bus_read(8'h08, d, e);
        check("txdata_read", d, 32'h0);
        check("mapped_err", {31'd0, e}, 32'd0);
        bus_write(8'h00, 32'h0000_0003, 4'h1);
        bus_read(8'h00, d, e);
        check("ctrl_be", d, 32'h0000_0703);
        bus_write(8'h00, 32'hFFFF_FFFF, 4'hF);
        bus_read(8'h00, d, e);
        check("ctrl_mask", d, CTRL_ALL);
        bus_write(8'h04, 32'h0000_000C, 4'h1);

`ifdef SPI_DEVICE_LOOPBACK_EN
        bus_write(8'h00, 32'h0000_1F21, 4'hF);
        bus_write(8'h08, 32'hDEAD_BEEF, 4'hF);
        spi_xfer(32'h0, 32, 1'b0, 1'b0, 1'b0, 99, 1'b0, miso);
        bus_read(8'h0C, d, e);
        check("loop_rxdata", d, 32'hDEAD_BEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
